aes_round_sequencer: RTL and testbench

Iterative-round controller for a shared AES round datapath supporting 128/192/256-bit keys. It accepts one job at a time over a valid/ready handshake and latches the key size and direction. It then drives the round-enable, round-key index and first/last-round strobes that step the datapath and key-schedule selector through Nr+1 AddRoundKey stages. It sits between the board-level control (switch decode, display latch) and the round datapath, replacing fixed per-key-size pipelines with one sequenced core.

---
 rtl/aes_round_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_sequencer
// Description : Iterative-round controller for a shared AES round datapath
//               (AES-128/192/256, encrypt or decrypt). Accepts one job at a
//               time over a valid/ready handshake, then steps the datapath
//               and key-schedule selector through Nr+1 AddRoundKey stages.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   i_req_valid   in   job request
//   o_req_ready   out  controller can accept a job (IDLE)
//   i_req_mode    in   01=AES-128, 10=AES-192, 11=AES-256, 00=illegal
//   i_req_dec     in   0=encrypt, 1=decrypt
//   i_abort       in   cancel the current job (RUN or DONE only)
//   o_round_en    out  datapath performs one round stage this cycle
//   o_round_idx   out  round-key index applied this cycle (0..Nr)
//   o_first_round out  initial AddRoundKey-only stage
//   o_last_round  out  stage that omits (Inv)MixColumns
//   o_dec_mode    out  latched direction of the active job
//   o_nr          out  latched Nr of the active job (10/12/14)
//   o_busy        out  job in progress (RUN or DONE)
//   o_done        out  one-cycle pulse, datapath result valid
//   o_err         out  one-cycle pulse, illegal mode rejected
//   o_jobs_done   out  completed-job counter, wraps 255->0
// ============================================================================
module aes_round_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [1:0] i_req_mode,
    input  logic       i_req_dec,
    input  logic       i_abort,
    output logic       o_round_en,
    output logic [3:0] o_round_idx,
    output logic       o_first_round,
    output logic       o_last_round,
    output logic       o_dec_mode,
    output logic [3:0] o_nr,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [7:0] o_jobs_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_round_en;
    logic [3:0] r_round_idx;
    logic       r_first;
    logic       r_last;
    logic       r_dec;
    logic [3:0] r_nr;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic [7:0] r_jobs;

    logic       w_round_en;
    logic [3:0] w_round_idx;
    logic       w_first;
    logic       w_last;
    logic       w_dec;
    logic [3:0] w_nr;
    logic       w_busy;
    logic       w_done;
    logic       w_err;
    logic [7:0] w_jobs;

    logic [3:0] w_mode_nr;
    logic [3:0] w_idx_step;
    logic [3:0] w_idx_end;

    // Round count for the requested key size; zero marks the illegal mode.
    always_comb begin
        w_mode_nr = 4'd0;
        case (i_req_mode)
            2'b01:   w_mode_nr = 4'd10;
            2'b10:   w_mode_nr = 4'd12;
            2'b11:   w_mode_nr = 4'd14;
            default: w_mode_nr = 4'd0;
        endcase
    end

    // Next index walks up for encrypt, down for decrypt; the final stage
    // is the opposite end of the key schedule from where the job started.
    assign w_idx_step = r_dec ? (r_round_idx - 4'd1) : (r_round_idx + 4'd1);
    assign w_idx_end  = r_dec ? 4'd0 : r_nr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output logic. Every output except ready is
    // registered, so the values computed here belong to the next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_round_en  = 1'b0;
        w_round_idx = r_round_idx;
        w_first     = 1'b0;
        w_last      = 1'b0;
        w_dec       = r_dec;
        w_nr        = r_nr;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_jobs      = r_jobs;

        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    if (w_mode_nr == 4'd0) begin
                        w_state_nxt = S_ERR;
                        w_err       = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_nr        = w_mode_nr;
                        w_dec       = i_req_dec;
                        w_round_en  = 1'b1;
                        w_busy      = 1'b1;
                        w_first     = 1'b1;
                        w_round_idx = i_req_dec ? w_mode_nr : 4'd0;
                    end
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_last) begin
                    w_state_nxt = S_DONE;
                    w_busy      = 1'b1;
                    w_done      = 1'b1;
                end else begin
                    w_round_en  = 1'b1;
                    w_busy      = 1'b1;
                    w_round_idx = w_idx_step;
                    w_last      = (w_idx_step == w_idx_end);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                // An abort during the done cycle discards the completion.
                if (!i_abort) begin
                    w_jobs = r_jobs + 8'd1;
                end
            end
            S_ERR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_round_en  <= 1'b0;
            r_round_idx <= 4'd0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_dec       <= 1'b0;
            r_nr        <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_jobs      <= 8'd0;
        end else begin
            r_round_en  <= w_round_en;
            r_round_idx <= w_round_idx;
            r_first     <= w_first;
            r_last      <= w_last;
            r_dec       <= w_dec;
            r_nr        <= w_nr;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_err       <= w_err;
            r_jobs      <= w_jobs;
        end
    end

    assign o_req_ready   = (r_state == S_IDLE);
    assign o_round_en    = r_round_en;
    assign o_round_idx   = r_round_idx;
    assign o_first_round = r_first;
    assign o_last_round  = r_last;
    assign o_dec_mode    = r_dec;
    assign o_nr          = r_nr;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_jobs_done   = r_jobs;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_sequencer
// Description : Self-checking bench for aes_round_sequencer. A job-level
//               model (cycles elapsed since acceptance) predicts every
//               output each cycle; directed sequences pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_mode = 2'b00;
    logic       req_dec = 1'b0;
    logic       abort = 1'b0;

    logic       req_ready;
    logic       round_en;
    logic [3:0] round_idx;
    logic       first_round;
    logic       last_round;
    logic       dec_mode;
    logic [3:0] nr;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] jobs_done;

    aes_round_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_mode    (req_mode),
        .i_req_dec     (req_dec),
        .i_abort       (abort),
        .o_round_en    (round_en),
        .o_round_idx   (round_idx),
        .o_first_round (first_round),
        .o_last_round  (last_round),
        .o_dec_mode    (dec_mode),
        .o_nr          (nr),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err),
        .o_jobs_done   (jobs_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Job-level model: m_t counts cycles since acceptance (0 = no job).
    // Cycles 1..nr+1 are round stages, cycle nr+2 is the done cycle.
    // ------------------------------------------------------------------
    int m_t    = 0;
    bit m_err  = 0;
    int m_nr   = 0;
    int m_dec  = 0;
    int m_jobs = 0;
    int m_idx  = 0;

    function automatic int mode_to_nr(input logic [1:0] m);
        case (m)
            2'b01:   return 10;
            2'b10:   return 12;
            2'b11:   return 14;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_run();
        return (m_t >= 1) && (m_t <= m_nr + 1);
    endfunction

    function automatic int m_stage_idx();
        return (m_dec != 0) ? (m_nr - (m_t - 1)) : (m_t - 1);
    endfunction

    always @(posedge clk or posedge reset) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_t = 0; m_err = 0; m_nr = 0; m_dec = 0; m_jobs = 0; m_idx = 0;
        end else begin
            if (m_err) begin
                m_err = 0;
            end else if (m_t > 0) begin
                if (abort) begin
                    m_t = 0;
                end else if (m_t == m_nr + 2) begin
                    m_t = 0;
                    m_jobs = (m_jobs + 1) % 256;
                end else begin
                    m_t = m_t + 1;
                end
            end else if (req_valid) begin
                if (mode_to_nr(req_mode) == 0) begin
                    m_err = 1;
                end else begin
                    m_t   = 1;
                    m_nr  = mode_to_nr(req_mode);
                    m_dec = int'(req_dec);
                end
            end
            if (m_run()) m_idx = m_stage_idx();
        end
    end

    always @(negedge clk) begin
        if (!reset && chk_on) begin
            chk("ready", req_ready, (m_t == 0 && !m_err));
            chk("round_en", round_en, m_run());
            chk("round_idx", round_idx, m_idx);
            chk("first_round", first_round, m_run() && m_t == 1);
            chk("last_round", last_round, m_run() && m_t == m_nr + 1);
            chk("dec_mode", dec_mode, m_dec);
            chk("nr", nr, m_nr);
            chk("busy", busy, m_t > 0);
            chk("done", done, m_t > 0 && m_t == m_nr + 2);
            chk("err", err, m_err);
            chk("jobs_done", jobs_done, m_jobs);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (!req_ready && g < 40) begin
            tick();
            g++;
        end
        chk("wait_idle", req_ready, 1);
    endtask

    initial begin
        int cnt;
        int g;
        int t;
        int a1;
        int a2;
        int s;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_ready", req_ready, 1);
        chk("rst_en", round_en, 0);
        chk("rst_idx", round_idx, 0);
        chk("rst_nr", nr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_jobs", jobs_done, 0);
        reset = 1'b0;
        chk_on = 1'b1;
        tick();

        // ---------------- AES-128 encrypt ----------------
        req_valid = 1; req_mode = 2'b01; req_dec = 0;
        tick();
        req_valid = 0;
        chk("e128_en0", round_en, 1);
        chk("e128_idx0", round_idx, 0);
        chk("e128_first0", first_round, 1);
        chk("e128_nr", nr, 10);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("e128_idx", round_idx, i);
            chk("e128_first", first_round, 0);
            chk("e128_last", last_round, (i == 10));
        end
        tick();
        chk("e128_done", done, 1);
        chk("e128_en_off", round_en, 0);
        tick();
        chk("e128_ready", req_ready, 1);
        chk("e128_jobs", jobs_done, 1);

        // ---------------- AES-256 decrypt ----------------
        req_valid = 1; req_mode = 2'b11; req_dec = 1;
        tick();
        req_valid = 0;
        chk("d256_idx14", round_idx, 14);
        chk("d256_nr", nr, 14);
        chk("d256_dec", dec_mode, 1);
        chk("d256_first", first_round, 1);
        cnt = 1; t = 1; g = 0;
        while (round_en && g < 30) begin
            tick();
            t++; g++;
            if (round_en) cnt++;
        end
        chk("d256_rounds", cnt, 15);
        chk("d256_done_lat", t, 16);
        chk("d256_done", done, 1);
        tick();
        chk("d256_jobs", jobs_done, 2);

        // ---------------- illegal mode ----------------
        req_valid = 1; req_mode = 2'b00; req_dec = 0;
        tick();
        req_valid = 0;
        chk("ill_err", err, 1);
        chk("ill_ready", req_ready, 0);
        chk("ill_en", round_en, 0);
        chk("ill_nr", nr, 14);
        chk("ill_dec", dec_mode, 1);
        tick();
        chk("ill_ready2", req_ready, 1);
        chk("ill_err2", err, 0);
        chk("ill_done", done, 0);

        // ---------------- AES-192 abort at idx 5 ----------------
        req_valid = 1; req_mode = 2'b10; req_dec = 0;
        tick();
        req_valid = 0;
        g = 0;
        while (!(round_en && round_idx == 5) && g < 20) begin
            tick();
            g++;
        end
        chk("abt_reach5", round_idx, 5);
        abort = 1;
        tick();
        abort = 0;
        chk("abt_en", round_en, 0);
        chk("abt_busy", busy, 0);
        chk("abt_ready", req_ready, 1);
        cnt = 0;
        repeat (4) begin
            if (done) cnt++;
            tick();
        end
        chk("abt_nodone", cnt, 0);
        chk("abt_jobs", jobs_done, 2);
        req_valid = 1; req_mode = 2'b01; req_dec = 0;
        tick();
        req_valid = 0;
        chk("abt_next_en", round_en, 1);
        chk("abt_next_idx", round_idx, 0);
        wait_idle();
        chk("abt_next_jobs", jobs_done, 3);

        // ---------------- back-to-back ----------------
        req_valid = 1; req_mode = 2'b01; req_dec = 0;
        a1 = cyc;
        tick();
        req_mode = 2'b10;
        g = 0;
        while (!req_ready && g < 40) begin
            tick();
            g++;
        end
        a2 = cyc;
        chk("b2b_period", a2 - a1, 13);
        tick();
        req_valid = 0;
        chk("b2b_nr", nr, 12);
        wait_idle();

        // ---------------- 256 jobs, counter wrap ----------------
        s = jobs_done;
        cnt = 0; g = 0;
        req_valid = 1;
        while (cnt < 256 && g < 6000) begin
            req_mode = 2'($urandom_range(1, 3));
            req_dec  = 1'($urandom_range(0, 1));
            tick();
            g++;
            if (done) cnt++;
            if (cnt == 256) req_valid = 0;
        end
        req_valid = 0;
        chk("wrap_count", cnt, 256);
        tick();
        chk("wrap_jobs", jobs_done, s);

        // ---------------- random traffic ----------------
        repeat (2000) begin
            req_valid = 1'($urandom_range(0, 1));
            req_mode  = 2'($urandom_range(0, 3));
            req_dec   = 1'($urandom_range(0, 1));
            abort     = ($urandom_range(0, 15) == 0);
            tick();
        end
        req_valid = 0;
        abort = 0;
        wait_idle();

        // ---------------- asynchronous reset mid-RUN ----------------
        req_valid = 1; req_mode = 2'b11; req_dec = 0;
        tick();
        req_valid = 0;
        repeat (4) tick();
        @(posedge clk);
        #3;
        reset = 1;
        #1;
        chk("arst_ready", req_ready, 1);
        chk("arst_en", round_en, 0);
        chk("arst_idx", round_idx, 0);
        chk("arst_busy", busy, 0);
        chk("arst_nr", nr, 0);
        chk("arst_jobs", jobs_done, 0);
        @(negedge clk);
        #1;
        reset = 0;
        cnt = 0;
        repeat (20) begin
            tick();
            if (done || round_en) cnt++;
        end
        chk("arst_quiet", cnt, 0);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
